// File: rtl/ysyx_25040101_lsu.sv
// Multi-cycle load/store unit: valid/ready request from execute, valid/ready bus access,
// lane alignment, write strobes, load extension and error reporting.
module ysyx_25040101_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_wen_i,
  input  logic [1:0]          req_size_i,
  input  logic                req_unsigned_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [XLEN-1:0]     req_wdata_i,
  output logic                resp_valid_o,
  input  logic                resp_ready_i,
  output logic [XLEN-1:0]     resp_rdata_o,
  output logic                resp_err_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic                mem_wen_o,
  output logic [XLEN-1:0]     mem_wdata_o,
  output logic [XLEN/8-1:0]   mem_wstrb_o,
  input  logic                mem_rsp_valid_i,
  input  logic [XLEN-1:0]     mem_rsp_rdata_i,
  input  logic                mem_rsp_err_i
);
  localparam int SB    = XLEN / 8;
  localparam int OFF_W = $clog2(SB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]        state;
  logic              wen;
  logic              uns;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;
  logic              err;

  logic [OFF_W-1:0]  off;
  logic [OFF_W+2:0]  shamt;
  logic [SB-1:0]     bmask;
  logic [XLEN-1:0]   wmask;
  logic [XLEN-1:0]   raw;
  logic [XLEN-1:0]   ext;
  logic              sign_bit;
  logic              fill;
  logic              bad;

  assign off   = addr[OFF_W-1:0];
  assign shamt = {off, 3'b000};
  assign raw   = mem_rsp_rdata_i >> shamt;
  assign fill  = ~uns & sign_bit;

  // Per-byte view: bmask marks the low nb bytes of a right-aligned operand.
  for (genvar gi = 0; gi < SB; gi++) begin : g_lane
    assign bmask[gi]         = (32'(gi) < (32'd1 << size));
    assign wmask[8*gi +: 8]  = bmask[gi] ? wdata[8*gi +: 8] : 8'h00;
    assign ext[8*gi +: 8]    = bmask[gi] ? raw[8*gi +: 8] : {8{fill}};
  end

  always_comb begin
    case (size)
      2'd0:    sign_bit = raw[7];
      2'd1:    sign_bit = raw[15];
      2'd2:    sign_bit = raw[31];
      default: sign_bit = raw[XLEN-1];
    endcase
  end

  // Size 3 is never legal on a 32-bit build, whatever the address.
  always_comb begin
    case (req_size_i)
      2'd0:    bad = 1'b0;
      2'd1:    bad = req_addr_i[0];
      2'd2:    bad = |req_addr_i[1:0];
      default: bad = (XLEN == 32) || (|req_addr_i[2:0]);
    endcase
  end

  assign req_ready_o  = (state == S_IDLE);
  assign resp_valid_o = (state == S_RESP);
  assign resp_rdata_o = rdata;
  assign resp_err_o   = err;
  assign mem_valid_o  = (state == S_REQ);
  assign mem_wen_o    = mem_valid_o & wen;
  assign mem_addr_o   = mem_valid_o ? {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_wdata_o  = mem_wen_o ? (wmask << shamt) : '0;
  assign mem_wstrb_o  = mem_wen_o ? (bmask << off) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      wen   <= 1'b0;
      uns   <= 1'b0;
      size  <= 2'd0;
      addr  <= '0;
      wdata <= '0;
      rdata <= '0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            wen   <= req_wen_i;
            uns   <= req_unsigned_i;
            size  <= req_size_i;
            addr  <= req_addr_i;
            wdata <= req_wdata_i;
            rdata <= '0;
            err   <= bad;
            state <= bad ? S_RESP : S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ready_i) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_rsp_valid_i) begin
            rdata <= (wen || mem_rsp_err_i) ? '0 : ext;
            err   <= mem_rsp_err_i;
            state <= S_RESP;
          end
        end
        default: begin
          if (resp_ready_i) state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25040101_lsu.sv
// Directed bench for ysyx_25040101_lsu: a 32-bit and a 64-bit instance driven by
// hand-computed vectors, one task per scenario.
module tb_ysyx_25040101_lsu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_wen, req_uns, resp_ready, mem_ready, mem_rsp_valid, mem_rsp_err;
  logic [1:0]  req_size;
  logic [31:0] req_addr;

  logic        req_valid32, req_ready32, resp_valid32, resp_err32, mem_valid32, mem_wen32;
  logic [31:0] req_wdata32, resp_rdata32, mem_addr32, mem_wdata32, mem_rsp_rdata32;
  logic [3:0]  mem_wstrb32;

  logic        req_valid64, req_ready64, resp_valid64, resp_err64, mem_valid64, mem_wen64;
  logic [63:0] req_wdata64, resp_rdata64, mem_wdata64, mem_rsp_rdata64;
  logic [31:0] mem_addr64;
  logic [7:0]  mem_wstrb64;

  int vec_cnt = 0;
  int err_cnt = 0;
  int hs32 = 0;

  always @(posedge clk) if (rst && mem_valid32 && mem_ready) hs32 <= hs32 + 1;

  ysyx_25040101_lsu #(.XLEN(32), .ADDR_W(32)) u32 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid32), .req_ready_o(req_ready32), .req_wen_i(req_wen),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata32), .resp_valid_o(resp_valid32), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata32), .resp_err_o(resp_err32), .mem_valid_o(mem_valid32),
    .mem_ready_i(mem_ready), .mem_addr_o(mem_addr32), .mem_wen_o(mem_wen32),
    .mem_wdata_o(mem_wdata32), .mem_wstrb_o(mem_wstrb32), .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_rdata_i(mem_rsp_rdata32), .mem_rsp_err_i(mem_rsp_err)
  );

  ysyx_25040101_lsu #(.XLEN(64), .ADDR_W(32)) u64 (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid64), .req_ready_o(req_ready64), .req_wen_i(req_wen),
    .req_size_i(req_size), .req_unsigned_i(req_uns), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata64), .resp_valid_o(resp_valid64), .resp_ready_i(resp_ready),
    .resp_rdata_o(resp_rdata64), .resp_err_o(resp_err64), .mem_valid_o(mem_valid64),
    .mem_ready_i(mem_ready), .mem_addr_o(mem_addr64), .mem_wen_o(mem_wen64),
    .mem_wdata_o(mem_wdata64), .mem_wstrb_o(mem_wstrb64), .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_rdata_i(mem_rsp_rdata64), .mem_rsp_err_i(mem_rsp_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_cnt++; if (req_ready32 !== 1'b1) begin err_cnt++; $display("FAIL rst_req_ready: got %h want 1", req_ready32); end
    vec_cnt++; if ({resp_valid32, resp_err32, resp_rdata32} !== 34'h0) begin err_cnt++; $display("FAIL rst_resp: got v=%h e=%h d=%h want 0", resp_valid32, resp_err32, resp_rdata32); end
    vec_cnt++; if ({mem_valid32, mem_wen32, mem_addr32, mem_wdata32, mem_wstrb32} !== 70'h0) begin err_cnt++; $display("FAIL rst_mem: got v=%h w=%h a=%h d=%h s=%h want 0", mem_valid32, mem_wen32, mem_addr32, mem_wdata32, mem_wstrb32); end
    vec_cnt++; if ({req_ready64, resp_valid64, mem_valid64} !== 3'b100) begin err_cnt++; $display("FAIL rst_64: got %b want 100", {req_ready64, resp_valid64, mem_valid64}); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_load_byte();
    req_valid32 = 1'b1; req_wen = 1'b0; req_size = 2'd0; req_uns = 1'b0; req_addr = 32'h1003;
    @(negedge clk);
    vec_cnt++; if (req_ready32 !== 1'b1) begin err_cnt++; $display("FAIL lb_req_ready: got %h want 1", req_ready32); end
    step();
    req_valid32 = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    vec_cnt++; if ({mem_valid32, mem_wen32, mem_addr32, mem_wstrb32} !== {1'b1, 1'b0, 32'h1000, 4'h0}) begin err_cnt++; $display("FAIL lb_mem_req: got v=%h w=%h a=%h s=%h want v=1 w=0 a=1000 s=0", mem_valid32, mem_wen32, mem_addr32, mem_wstrb32); end
    vec_cnt++; if (req_ready32 !== 1'b0) begin err_cnt++; $display("FAIL lb_busy: got req_ready=%h want 0", req_ready32); end
    step();
    mem_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata32 = 32'h80FF_1234;
    @(negedge clk);
    vec_cnt++; if (resp_valid32 !== 1'b0) begin err_cnt++; $display("FAIL lb_early_resp: got %h want 0", resp_valid32); end
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    vec_cnt++; if ({resp_valid32, resp_err32, resp_rdata32} !== {1'b1, 1'b0, 32'hFFFF_FF80}) begin err_cnt++; $display("FAIL lb_resp: got v=%h e=%h d=%h want v=1 e=0 d=ffffff80", resp_valid32, resp_err32, resp_rdata32); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    @(negedge clk);
    vec_cnt++; if ({resp_valid32, req_ready32} !== 2'b01) begin err_cnt++; $display("FAIL lb_done: got %b want 01", {resp_valid32, req_ready32}); end
  endtask

  task automatic test_store_half();
    req_valid32 = 1'b1; req_wen = 1'b1; req_size = 2'd1; req_uns = 1'b0; req_addr = 32'h2002; req_wdata32 = 32'hDEAD_BEEF;
    step();
    req_valid32 = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    vec_cnt++; if (mem_wdata32 !== 32'hBEEF_0000) begin err_cnt++; $display("FAIL sh_wdata: got %h want beef0000", mem_wdata32); end
    vec_cnt++; if (mem_wstrb32 !== 4'b1100) begin err_cnt++; $display("FAIL sh_wstrb: got %b want 1100", mem_wstrb32); end
    vec_cnt++; if ({mem_valid32, mem_wen32, mem_addr32} !== {1'b1, 1'b1, 32'h2000}) begin err_cnt++; $display("FAIL sh_req: got v=%h w=%h a=%h want v=1 w=1 a=2000", mem_valid32, mem_wen32, mem_addr32); end
    step();
    mem_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata32 = 32'h1234_5678;
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    vec_cnt++; if ({resp_valid32, resp_err32, resp_rdata32} !== {1'b1, 1'b0, 32'h0}) begin err_cnt++; $display("FAIL sh_resp: got v=%h e=%h d=%h want v=1 e=0 d=0", resp_valid32, resp_err32, resp_rdata32); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    // lw at 0x1001, then a double access on the 32-bit build; neither may reach the bus.
    for (int k = 0; k < 2; k++) begin
      int hs0;
      hs0 = hs32;
      req_valid32 = 1'b1; req_wen = 1'b0; req_uns = 1'b0;
      req_size = (k == 0) ? 2'd2 : 2'd3;
      req_addr = (k == 0) ? 32'h1001 : 32'h1000;
      step();
      req_valid32 = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      vec_cnt++; if ({resp_valid32, resp_err32, resp_rdata32} !== {1'b1, 1'b1, 32'h0}) begin err_cnt++; $display("FAIL err_resp%0d: got v=%h e=%h d=%h want v=1 e=1 d=0", k, resp_valid32, resp_err32, resp_rdata32); end
      vec_cnt++; if (mem_valid32 !== 1'b0) begin err_cnt++; $display("FAIL err_no_bus%0d: got mem_valid=%h want 0", k, mem_valid32); end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0; mem_ready = 1'b0;
      @(negedge clk);
      vec_cnt++; if ({req_ready32, mem_valid32, hs32 - hs0} !== {1'b1, 1'b0, 32'd0}) begin err_cnt++; $display("FAIL err_idle%0d: got rdy=%h mv=%h hs=%0d want rdy=1 mv=0 hs=0", k, req_ready32, mem_valid32, hs32 - hs0); end
    end
  endtask

  task automatic test_word64();
    logic [63:0] exp_d;
    for (int k = 0; k < 2; k++) begin
      exp_d = (k == 0) ? 64'h0000_0000_8765_4321 : 64'hFFFF_FFFF_8765_4321;
      req_valid64 = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_uns = (k == 0); req_addr = 32'h1004;
      step();
      req_valid64 = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      vec_cnt++; if ({mem_valid64, mem_addr64, mem_wstrb64} !== {1'b1, 32'h1000, 8'h00}) begin err_cnt++; $display("FAIL w64_req%0d: got v=%h a=%h s=%h want v=1 a=1000 s=0", k, mem_valid64, mem_addr64, mem_wstrb64); end
      step();
      mem_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata64 = 64'h8765_4321_0000_0000;
      step();
      mem_rsp_valid = 1'b0;
      @(negedge clk);
      vec_cnt++; if ({resp_valid64, resp_err64, resp_rdata64} !== {1'b1, 1'b0, exp_d}) begin err_cnt++; $display("FAIL w64_resp%0d: got v=%h e=%h d=%h want v=1 e=0 d=%h", k, resp_valid64, resp_err64, resp_rdata64, exp_d); end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int hs0;
    hs0 = hs32;
    req_valid32 = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_addr = 32'h3000;
    step();
    req_valid32 = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mem_rsp_valid = (i == 2); mem_rsp_rdata32 = 32'hAAAA_5555;
      @(negedge clk);
      vec_cnt++; if ({mem_valid32, req_ready32, mem_addr32, resp_valid32} !== {1'b1, 1'b0, 32'h3000, 1'b0}) begin err_cnt++; $display("FAIL bp_req%0d: got v=%h rdy=%h a=%h rv=%h want v=1 rdy=0 a=3000 rv=0", i, mem_valid32, req_ready32, mem_addr32, resp_valid32); end
      step();
    end
    mem_rsp_valid = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    @(negedge clk);
    vec_cnt++; if ({mem_valid32, resp_valid32} !== 2'b00) begin err_cnt++; $display("FAIL bp_wait: got %b want 00", {mem_valid32, resp_valid32}); end
    mem_rsp_valid = 1'b1; mem_rsp_rdata32 = 32'h1234_5678; mem_rsp_err = 1'b1;
    step();
    mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      resp_ready = (i == 3);
      @(negedge clk);
      vec_cnt++; if ({resp_valid32, resp_err32, resp_rdata32, req_ready32} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin err_cnt++; $display("FAIL bp_resp%0d: got v=%h e=%h d=%h rdy=%h want v=1 e=1 d=0 rdy=0", i, resp_valid32, resp_err32, resp_rdata32, req_ready32); end
      step();
    end
    resp_ready = 1'b0;
    @(negedge clk);
    vec_cnt++; if ({resp_valid32, req_ready32} !== 2'b01) begin err_cnt++; $display("FAIL bp_done: got %b want 01", {resp_valid32, req_ready32}); end
    vec_cnt++; if (hs32 - hs0 !== 1) begin err_cnt++; $display("FAIL bp_handshakes: got %0d want 1", hs32 - hs0); end
  endtask

  task automatic test_reset_mid();
    req_valid32 = 1'b1; req_wen = 1'b0; req_size = 2'd0; req_uns = 1'b1; req_addr = 32'h1001;
    step();
    req_valid32 = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    vec_cnt++; if ({req_ready32, resp_valid32, mem_valid32, mem_addr32, resp_err32, resp_rdata32} !== {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0}) begin err_cnt++; $display("FAIL mid_rst: got rdy=%h rv=%h mv=%h a=%h e=%h d=%h want rdy=1 rest 0", req_ready32, resp_valid32, mem_valid32, mem_addr32, resp_err32, resp_rdata32); end
    step();
    rst = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_rdata32 = 32'hFFFF_FFFF;
    step();
    mem_rsp_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vec_cnt++; if ({resp_valid32, req_ready32, mem_valid32} !== 3'b010) begin err_cnt++; $display("FAIL mid_stray%0d: got %b want 010", i, {resp_valid32, req_ready32, mem_valid32}); end
      step();
    end
    req_valid32 = 1'b1;
    step();
    req_valid32 = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    vec_cnt++; if ({mem_valid32, mem_addr32} !== {1'b1, 32'h1000}) begin err_cnt++; $display("FAIL mid_req: got v=%h a=%h want v=1 a=1000", mem_valid32, mem_addr32); end
    step();
    mem_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata32 = 32'h0000_8000;
    step();
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    vec_cnt++; if ({resp_valid32, resp_err32, resp_rdata32} !== {1'b1, 1'b0, 32'h0000_0080}) begin err_cnt++; $display("FAIL mid_lbu: got v=%h e=%h d=%h want v=1 e=0 d=80", resp_valid32, resp_err32, resp_rdata32); end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_wen = 1'b0; req_uns = 1'b0; req_size = 2'd0; req_addr = '0;
    resp_ready = 1'b0; mem_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    req_valid32 = 1'b0; req_wdata32 = '0; mem_rsp_rdata32 = '0;
    req_valid64 = 1'b0; req_wdata64 = '0; mem_rsp_rdata64 = '0;
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_word64();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
